key_search_controller: RTL and testbench

//  Initiator side of the key-generator start/finished/terminated handshake. It requests keys one at a

---
 rtl/key_search_controller.sv | 137 +++++++++++++
 tb/tb_key_search_controller.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/key_search_controller.sv
// Key search initiator: requests keys from the generator one at a time, launches decrypt, stops on first valid key or after the last key.
// Optional dec_done watchdog enabled by defining KEY_SEARCH_TIMEOUT_EN.
module key_search_controller #(
   parameter int KEY_W          = 24,
   parameter int CNT_W          = 25,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             go,
   output logic             kg_start,
   input  logic             kg_finished,
   input  logic             kg_terminated,
   input  logic [KEY_W-1:0] kg_key,
   output logic [KEY_W-1:0] dec_key,
   output logic             dec_start,
   input  logic             dec_done,
   input  logic             dec_valid,
   output logic             busy,
   output logic             found,
   output logic             exhausted,
   output logic [CNT_W-1:0] keys_tried,
   output logic             timeout_err
);

   typedef enum logic [2:0] {
      S_IDLE, S_REQ, S_WAIT_KG, S_LAUNCH, S_WAIT_DEC, S_FOUND, S_EXHAUSTED
   } state_t;

   state_t state, state_nxt;
   logic   go_q, go_rise, restart, kg_hit, last, wd_fire, dec_end, dec_ok;

   assign go_rise = go & ~go_q;
   assign restart = go_rise & ((state == S_IDLE) | (state == S_FOUND) | (state == S_EXHAUSTED));
   assign kg_hit  = (state == S_WAIT_KG) & (kg_finished | kg_terminated);
   assign dec_ok  = (state == S_WAIT_DEC) & dec_done & dec_valid;
   // A watchdog expiry is handled exactly like a rejected key.
   assign dec_end = (state == S_WAIT_DEC) & (dec_done | wd_fire);

`ifdef KEY_SEARCH_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [WD_W-1:0] wd_cnt;
   logic            timeout_q;

   // The flag is raised on the cycle the limit is reached; the FSM moves on one cycle later.
   always_ff @(posedge clk) begin
      if (reset) begin
         wd_cnt    <= '0;
         timeout_q <= 1'b0;
      end else begin
         if (state != S_WAIT_DEC)
            wd_cnt <= '0;
         else if (wd_cnt != WD_W'(TIMEOUT_CYCLES))
            wd_cnt <= wd_cnt + 1'b1;
         if (restart)
            timeout_q <= 1'b0;
         else if ((state == S_WAIT_DEC) && !dec_done && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1)))
            timeout_q <= 1'b1;
      end
   end

   assign wd_fire     = (state == S_WAIT_DEC) & (wd_cnt == WD_W'(TIMEOUT_CYCLES));
   assign timeout_err = timeout_q;
`else
   logic unused_cfg;
   assign unused_cfg  = (TIMEOUT_CYCLES != 0);
   assign wd_fire     = 1'b0;
   assign timeout_err = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      kg_start  = 1'b0;
      dec_start = 1'b0;
      busy      = 1'b1;
      case (state)
         S_IDLE: begin
            busy = 1'b0;
            if (go_rise) state_nxt = S_REQ;
         end
         S_REQ: begin
            kg_start  = 1'b1;
            state_nxt = S_WAIT_KG;
         end
         S_WAIT_KG: begin
            if (kg_finished | kg_terminated) state_nxt = S_LAUNCH;
         end
         S_LAUNCH: begin
            dec_start = 1'b1;
            state_nxt = S_WAIT_DEC;
         end
         S_WAIT_DEC: begin
            if (dec_ok)       state_nxt = S_FOUND;
            else if (dec_end) state_nxt = last ? S_EXHAUSTED : S_REQ;
         end
         S_FOUND, S_EXHAUSTED: begin
            busy = 1'b0;
            if (go_rise) state_nxt = S_REQ;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         go_q       <= 1'b0;
         dec_key    <= '0;
         last       <= 1'b0;
         found      <= 1'b0;
         exhausted  <= 1'b0;
         keys_tried <= '0;
      end else begin
         go_q <= go;
         if (restart) begin
            found      <= 1'b0;
            exhausted  <= 1'b0;
            keys_tried <= '0;
         end
         // Terminated wins when both generator pulses coincide.
         if (kg_hit) begin
            dec_key <= kg_key;
            last    <= kg_terminated;
         end
         if (dec_end) begin
            if (keys_tried != '1) keys_tried <= keys_tried + 1'b1;
            if (dec_ok)           found      <= 1'b1;
            else if (last)        exhausted  <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_key_search_controller.sv
// Bench for key_search_controller: generator and decrypt models, key scoreboard, end-of-search checks.
module tb_key_search_controller;
   localparam int KEY_W = 24;
   localparam int CNT_W = 25;

   logic             clk = 1'b0;
   logic             reset, go;
   logic             kg_start, kg_finished, kg_terminated;
   logic [KEY_W-1:0] kg_key, dec_key;
   logic             dec_start, dec_done, dec_valid;
   logic             busy, found, exhausted, timeout_err;
   logic [CNT_W-1:0] keys_tried;

   int total = 0, bad = 0;
   int kg_cnt = 0, ds_cnt = 0, b2b = 0;
   logic kg_prev = 1'b0;
   int lo = 0, hi = 3, cur = 0, valid_key = 2;
   bit both_mode = 0, valid_en = 1, dec_en = 1;
   int stray_kg_req = 0, stray_dn_req = 0;
   logic [KEY_W-1:0] exp_q[$];

   key_search_controller #(.KEY_W(KEY_W), .CNT_W(CNT_W), .TIMEOUT_CYCLES(8)) dut (
      .clk(clk), .reset(reset), .go(go),
      .kg_start(kg_start), .kg_finished(kg_finished), .kg_terminated(kg_terminated), .kg_key(kg_key),
      .dec_key(dec_key), .dec_start(dec_start), .dec_done(dec_done), .dec_valid(dec_valid),
      .busy(busy), .found(found), .exhausted(exhausted), .keys_tried(keys_tried),
      .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Pulse counter and scoreboard: every dec_start must carry the oldest key the generator issued.
   initial begin
      forever begin
         @(negedge clk);
         if (kg_start) begin
            kg_cnt++;
            if (kg_prev) b2b++;
         end
         kg_prev = kg_start;
         if (dec_start) begin
            ds_cnt++;
            check("sb_nonempty", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) check("dec_key_sb", 32'(dec_key), 32'(exp_q.pop_front()));
         end
      end
   end

   // Key generator model over [lo,hi]; wraps to lo after the terminated key.
   initial begin
      int ack = 0;
      kg_finished = 0; kg_terminated = 0; kg_key = '0;
      forever begin
         @(negedge clk);
         if (stray_kg_req != ack) begin
            ack++;
            kg_key = KEY_W'(7); kg_terminated = 1; kg_finished = 1;
            @(negedge clk);
            kg_terminated = 0; kg_finished = 0;
         end else if (kg_start && !reset) begin
            repeat (2) @(negedge clk);
            kg_key = KEY_W'(cur);
            if (both_mode)      begin kg_finished = 1; kg_terminated = 1; end
            else if (cur == hi) kg_terminated = 1;
            else                kg_finished = 1;
            exp_q.push_back(KEY_W'(cur));
            @(negedge clk);
            kg_finished = 0; kg_terminated = 0;
            cur = (cur == hi) ? lo : cur + 1;
         end
      end
   end

   // Decrypt/check model: accepts only valid_key when valid_en is set.
   initial begin
      int ack = 0;
      logic [KEY_W-1:0] k;
      dec_done = 0; dec_valid = 0;
      forever begin
         @(negedge clk);
         if (stray_dn_req != ack) begin
            ack++;
            dec_done = 1; dec_valid = 1;
            @(negedge clk);
            dec_done = 0; dec_valid = 0;
         end else if (dec_start && dec_en) begin
            k = dec_key;
            repeat (3) @(negedge clk);
            dec_done = 1;
            dec_valid = valid_en && (k == KEY_W'(valid_key));
            @(negedge clk);
            dec_done = 0; dec_valid = 0;
         end
      end
   end

   task automatic start_search(input string tag);
      go = 1;
      @(negedge clk);
      check({tag, "_kg_lat"}, 32'(kg_start), 1);
      go = 0;
   endtask

   task automatic wait_end(input string tag);
      int n = 0;
      while (!(found || exhausted) && n < 500) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_ended"}, 32'(found | exhausted), 1);
   endtask

   task automatic wait_dec_start(input string tag);
      int n = 0;
      while (!dec_start && n < 100) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_dec_start"}, 32'(dec_start), 1);
   endtask

   initial begin
      int k0, d0, n;
      reset = 1; go = 0;
      repeat (3) @(negedge clk);
      reset = 0;
      @(negedge clk);
      check("rst_busy", 32'(busy), 0);
      check("rst_found", 32'(found), 0);
      check("rst_exh", 32'(exhausted), 0);
      check("rst_kt", 32'(keys_tried), 0);
      check("rst_dkey", 32'(dec_key), 0);
      check("rst_kgs", 32'(kg_start), 0);
      check("rst_dst", 32'(dec_start), 0);
      check("rst_to", 32'(timeout_err), 0);
      repeat (20) @(negedge clk);
      check("idle_no_kg", 32'(kg_cnt), 0);

      // Range [0,3], key 2 valid; go drops right after launch.
      k0 = kg_cnt; lo = 0; hi = 3; cur = 0; valid_en = 1; valid_key = 2;
      start_search("find");
      wait_end("find");
      check("find_found", 32'(found), 1);
      check("find_exh", 32'(exhausted), 0);
      check("find_key", 32'(dec_key), 2);
      check("find_kt", 32'(keys_tried), 3);
      check("find_kgs", 32'(kg_cnt - k0), 3);
      check("find_busy", 32'(busy), 0);

      // Range [0,3], nothing valid.
      repeat (3) @(negedge clk);
      d0 = ds_cnt; cur = 0; valid_en = 0;
      start_search("exh");
      wait_end("exh");
      check("exh_exh", 32'(exhausted), 1);
      check("exh_found", 32'(found), 0);
      check("exh_kt", 32'(keys_tried), 4);
      check("exh_dst", 32'(ds_cnt - d0), 4);

      // finished and terminated together on key 5.
      repeat (3) @(negedge clk);
      lo = 5; hi = 9; cur = 5; both_mode = 1;
      start_search("both");
      wait_end("both");
      check("both_exh", 32'(exhausted), 1);
      check("both_kt", 32'(keys_tried), 1);
      check("both_key", 32'(dec_key), 5);
      check("both_found", 32'(found), 0);

      // Reset while waiting for the decrypt core, then stray pulses in IDLE.
      repeat (3) @(negedge clk);
      both_mode = 0; lo = 0; hi = 3; cur = 0; dec_en = 0;
      start_search("rst");
      wait_dec_start("rst");
      repeat (2) @(negedge clk);
      check("rst_mid_busy", 32'(busy), 1);
      reset = 1;
      @(negedge clk);
      check("rst_mid_idle", 32'(busy), 0);
      reset = 0;
      stray_dn_req++;
      repeat (4) @(negedge clk);
      check("stray_dn_kt", 32'(keys_tried), 0);
      check("stray_dn_found", 32'(found), 0);
      check("stray_dn_busy", 32'(busy), 0);
      k0 = kg_cnt;
      stray_kg_req++;
      repeat (4) @(negedge clk);
      check("stray_kg_req", 32'(kg_cnt - k0), 0);
      check("stray_kg_busy", 32'(busy), 0);

      // Withheld dec_done.
      cur = 0;
      start_search("wd");
      wait_dec_start("wd");
`ifdef KEY_SEARCH_TIMEOUT_EN
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!timeout_err && n < 30);
      check("wd_lat", 32'(n), 9);
      check("wd_kgs_pre", 32'(kg_start), 0);
      @(negedge clk);
      check("wd_kgs_next", 32'(kg_start), 1);
      check("wd_kt", 32'(keys_tried), 1);
      repeat (10) @(negedge clk);
`else
      n = 0;
      repeat (40) @(negedge clk);
      check("wd_busy", 32'(busy), 1);
      check("wd_to", 32'(timeout_err), 0);
      check("wd_kt", 32'(keys_tried), 0);
      check("wd_kgs", 32'(kg_start), 0);
`endif
      reset = 1;
      repeat (2) @(negedge clk);
      reset = 0;
      repeat (4) @(negedge clk);
      check("b2b_kg", 32'(b2b), 0);
      check("sb_drain", 32'(exp_q.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
